wr_dec_scoreboard: RTL and testbench

Parametrised register-file write-enable decoder with an integrated pending-write scoreboard for the pipelined datapath.
- Decodes the writeback destination into a registered one-hot write enable for the register file.
- Tracks which registers have an in-flight producer, from issue until writeback.
- Reports read hazards for two source operands and rejects WAW issues.
- Suppresses all decode and tracking for the hard-wired zero register.

---
 rtl/wr_dec_scoreboard.sv | 94 +++++++++
 tb/tb_wr_dec_scoreboard.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/wr_dec_scoreboard.sv
// Register-file write-enable decoder with a pending-write scoreboard.
// Tracks in-flight producers from issue to writeback and flags RAW/WAW hazards.
module wr_dec_scoreboard #(
  parameter int unsigned SEL_W    = 5,
  parameter bit          ZERO_EN  = 1'b1,
  parameter int unsigned ZERO_IDX = 31,
  localparam int unsigned NREG    = 2**SEL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_en,
  input  logic [SEL_W-1:0] issue_sel,
  output logic             issue_rej,
  input  logic             wb_en,
  input  logic [SEL_W-1:0] wb_sel,
  output logic [NREG-1:0]  wr_en_out,
  input  logic [SEL_W-1:0] rd_sel_a,
  input  logic [SEL_W-1:0] rd_sel_b,
  output logic             hazard_a,
  output logic             hazard_b,
  output logic [NREG-1:0]  pending,
  output logic [SEL_W:0]   pending_cnt,
  output logic             err_orphan
);

  localparam logic [SEL_W-1:0] ZSEL = ZERO_IDX[SEL_W-1:0];

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] r_wr_en;
  logic [SEL_W:0]  r_cnt;
  logic            r_err;

  logic            w_wb_act;
  logic            w_iss_act;
  logic            w_iss_set;
  logic            w_rej;
  logic [NREG-1:0] w_pend_nxt;
  logic [NREG-1:0] w_onehot;
  logic [SEL_W:0]  w_cnt_nxt;

  function automatic logic is_zero(input logic [SEL_W-1:0] sel);
    return ZERO_EN && (sel == ZSEL);
  endfunction

  assign w_wb_act  = wb_en && !is_zero(wb_sel);
  assign w_iss_act = issue_en && !is_zero(issue_sel);

  // A same-cycle writeback to the issue target retires the old producer, so no WAW.
  assign w_rej     = w_iss_act && r_pending[issue_sel] && !(wb_en && (wb_sel == issue_sel));
  assign w_iss_set = w_iss_act && !w_rej;

  assign hazard_a = r_pending[rd_sel_a] && !is_zero(rd_sel_a) && !(wb_en && (wb_sel == rd_sel_a));
  assign hazard_b = r_pending[rd_sel_b] && !is_zero(rd_sel_b) && !(wb_en && (wb_sel == rd_sel_b));

  // Set is applied after clear so a new producer overrides the retiring one.
  always_comb begin
    w_pend_nxt = r_pending;
    if (w_wb_act)  w_pend_nxt[wb_sel]    = 1'b0;
    if (w_iss_set) w_pend_nxt[issue_sel] = 1'b1;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      w_cnt_nxt = w_cnt_nxt + (SEL_W+1)'(w_pend_nxt[i]);
    end
  end

  always_comb begin
    w_onehot = '0;
    if (w_wb_act) w_onehot[wb_sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
      r_wr_en   <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= w_pend_nxt;
      r_wr_en   <= w_onehot;
      r_cnt     <= w_cnt_nxt;
      if (w_wb_act && !r_pending[wb_sel]) r_err <= 1'b1;
    end
  end

  assign issue_rej   = w_rej;
  assign wr_en_out   = r_wr_en;
  assign pending     = r_pending;
  assign pending_cnt = r_cnt;
  assign err_orphan  = r_err;

endmodule

// File: tb/tb_wr_dec_scoreboard.sv
// Bench for wr_dec_scoreboard: directed plan plus random traffic against a
// set-based reference model; a second 16-register instance without a zero register.
module tb_wr_dec_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_en, wb_en;
  logic [4:0]  issue_sel, wb_sel, rd_sel_a, rd_sel_b;
  logic        issue_rej, hazard_a, hazard_b, err_orphan;
  logic [31:0] wr_en_out, pending;
  logic [5:0]  pending_cnt;

  logic        b_issue_en, b_wb_en;
  logic [3:0]  b_issue_sel, b_wb_sel, b_rd_a, b_rd_b;
  logic        b_rej, b_haz_a, b_haz_b, b_err;
  logic [15:0] b_wr, b_pend;
  logic [4:0]  b_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: set of in-flight destinations, sticky orphan flag, last write strobe.
  bit          mp [32];
  bit          m_err;
  logic [31:0] m_wr;

  always #5 clk = ~clk;

  wr_dec_scoreboard #(.SEL_W(5), .ZERO_EN(1'b1), .ZERO_IDX(31)) dut_a (
    .clk(clk), .reset(reset),
    .issue_en(issue_en), .issue_sel(issue_sel), .issue_rej(issue_rej),
    .wb_en(wb_en), .wb_sel(wb_sel), .wr_en_out(wr_en_out),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
    .hazard_a(hazard_a), .hazard_b(hazard_b),
    .pending(pending), .pending_cnt(pending_cnt), .err_orphan(err_orphan)
  );

  wr_dec_scoreboard #(.SEL_W(4), .ZERO_EN(1'b0), .ZERO_IDX(15)) dut_b (
    .clk(clk), .reset(reset),
    .issue_en(b_issue_en), .issue_sel(b_issue_sel), .issue_rej(b_rej),
    .wb_en(b_wb_en), .wb_sel(b_wb_sel), .wr_en_out(b_wr),
    .rd_sel_a(b_rd_a), .rd_sel_b(b_rd_b),
    .hazard_a(b_haz_a), .hazard_b(b_haz_b),
    .pending(b_pend), .pending_cnt(b_cnt), .err_orphan(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit zf(input int sel);
    return sel == 31;
  endfunction

  function automatic logic [31:0] m_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = mp[i];
    return v;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(mp[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mp[i] = 1'b0;
    m_err = 1'b0;
    m_wr  = '0;
  endtask

  // One clock of traffic on instance A: check combinational outputs, then registered state.
  task automatic step(input bit ie, input int is, input bit we, input int ws,
                      input int ra, input int rb);
    bit e_rej, e_ha, e_hb;
    bit nxt [32];
    issue_en = ie; issue_sel = 5'(is);
    wb_en = we;    wb_sel = 5'(ws);
    rd_sel_a = 5'(ra); rd_sel_b = 5'(rb);
    #1;
    e_rej = ie && !zf(is) && mp[is] && !(we && ws == is);
    e_ha  = mp[ra] && !zf(ra) && !(we && ws == ra);
    e_hb  = mp[rb] && !zf(rb) && !(we && ws == rb);
    chk("issue_rej", 32'(issue_rej), 32'(e_rej));
    chk("hazard_a",  32'(hazard_a),  32'(e_ha));
    chk("hazard_b",  32'(hazard_b),  32'(e_hb));
    nxt  = mp;
    m_wr = '0;
    if (we && !zf(ws)) begin
      if (!mp[ws]) m_err = 1'b1;
      nxt[ws] = 1'b0;
      m_wr = 32'h1 << ws;
    end
    if (ie && !zf(is) && !e_rej) nxt[is] = 1'b1;
    mp = nxt;
    @(posedge clk); #1;
    chk("pending",     pending,           m_vec());
    chk("pending_cnt", 32'(pending_cnt),  32'(m_count()));
    chk("wr_en_out",   wr_en_out,         m_wr);
    chk("err_orphan",  32'(err_orphan),   32'(m_err));
  endtask

  function automatic int rsel();
    int r = $urandom_range(0, 9);
    if (r == 0) return 31;
    if (r < 7)  return $urandom_range(0, 7);
    return $urandom_range(0, 31);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    issue_en = 0; issue_sel = 0; wb_en = 0; wb_sel = 0; rd_sel_a = 0; rd_sel_b = 0;
    b_issue_en = 0; b_issue_sel = 0; b_wb_en = 0; b_wb_sel = 0; b_rd_a = 0; b_rd_b = 0;
    model_reset();
    #12;
    chk("rst_pending", pending, 32'h0);
    chk("rst_cnt",     32'(pending_cnt), 32'h0);
    chk("rst_wr",      wr_en_out, 32'h0);
    chk("rst_err",     32'(err_orphan), 32'h0);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Orphan writeback to 5
    step(0, 0, 1, 5, 0, 0);
    chk("orphan_wr",  wr_en_out, 32'h0000_0020);
    chk("orphan_err", 32'(err_orphan), 32'h1);

    // Issue 3, hazard, bypassed writeback
    step(1, 3, 0, 0, 3, 0);
    chk("iss3_cnt", 32'(pending_cnt), 32'h1);
    step(0, 0, 0, 0, 3, 3);
    step(0, 0, 1, 3, 3, 3);
    chk("wb3_wr", wr_en_out, 32'h8);

    // WAW on 7, then same-cycle replace
    step(1, 7, 0, 0, 7, 0);
    step(1, 7, 0, 0, 0, 7);
    chk("waw_cnt", 32'(pending_cnt), 32'h1);
    step(1, 7, 1, 7, 7, 7);
    chk("replace_p7", 32'(pending[7]), 32'h1);
    step(0, 0, 1, 7, 0, 0);

    // Zero register
    step(1, 31, 1, 31, 31, 31);
    chk("zero_wr", wr_en_out, 32'h0);

    // Decode sweep on both instances
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 32; i++) begin
        b_wb_en  = (pass == 1) && (i < 16);
        b_wb_sel = 4'(i);
        step(0, 0, pass == 1, i, $urandom_range(0, 31), $urandom_range(0, 31));
        if (i < 16) chk("b_wr", 32'(b_wr), (pass == 1) ? (32'h1 << i) : 32'h0);
      end
    end
    b_wb_en = 0;
    chk("b_err",  32'(b_err),  32'h1);
    chk("b_pend", 32'(b_pend), 32'h0);
    chk("b_cnt",  32'(b_cnt),  32'h0);

    // Fill every non-zero register, then async reset mid-cycle
    for (int i = 0; i < 31; i++) step(1, i, 0, 0, rsel(), rsel());
    chk("full_cnt", 32'(pending_cnt), 32'd31);
    step(0, 0, 1, 4, 4, 0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("arst_pending", pending, 32'h0);
    chk("arst_cnt",     32'(pending_cnt), 32'h0);
    chk("arst_wr",      wr_en_out, 32'h0);
    chk("arst_err",     32'(err_orphan), 32'h0);
    issue_en = 1; issue_sel = 5'd9; wb_en = 1; wb_sel = 5'd2;
    @(posedge clk); #1;
    chk("rsthold_pending", pending, 32'h0);
    chk("rsthold_err",     32'(err_orphan), 32'h0);
    issue_en = 0; wb_en = 0;
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 1), rsel(), $urandom_range(0, 2) != 0, rsel(), rsel(), rsel());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
